// File: rtl/ax_skip_decider_if.sv
// Request/decision bundle between the decode front end and ax_skip_decider.
// The master side drives requests, the level CSR and control; the slave side answers with decisions and stats.
interface ax_skip_decider_if #(
  parameter int LEVEL_WIDTH = 5,
  parameter int LANE_NUM    = 2,
  parameter int STAT_WIDTH  = 32
);
  logic                   levelWe;
  logic [LEVEL_WIDTH-1:0] levelIn;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   stall;
  logic                   flush;
  logic [LANE_NUM-1:0]    reqValid;
  logic [LANE_NUM-1:0]    decValid;
  logic [LANE_NUM-1:0]    decSkip;
  logic                   statClear;
  logic [STAT_WIDTH-1:0]  statReqCount;
  logic [STAT_WIDTH-1:0]  statSkipCount;

  modport master (
    output levelWe, levelIn, stall, flush, reqValid, statClear,
    input  level, decValid, decSkip, statReqCount, statSkipCount
  );

  modport slave (
    input  levelWe, levelIn, stall, flush, reqValid, statClear,
    output level, decValid, decSkip, statReqCount, statSkipCount
  );
endinterface

// File: rtl/ax_skip_decider.sv
// Per-lane approximate/skip decisions drawn from a Galois LFSR compared against a software level.
// Define RSD_AX_DECISION_STATS_EN to build the saturating request/skip statistics counters.
module ax_skip_decider #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = 'h1010,
  parameter int                    LEVEL_WIDTH = 5,
  parameter int                    LANE_NUM    = 2,
  parameter int                    STAT_WIDTH  = 32
) (
  input logic clk,
  input logic rst,
  ax_skip_decider_if.slave bus
);

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF  =
    (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;
  localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = LFSR_WIDTH'(32'h8020_0003);

  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [LANE_NUM-1:0]    dec_valid_q, dec_valid_d;
  logic [LANE_NUM-1:0]    dec_skip_q, dec_skip_d;
  logic [LANE_NUM-1:0]    skip_vec;
  logic                   accept;

  always_comb begin
    skip_vec = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      skip_vec[i] = bus.reqValid[i] &
                    (lfsr_q[i*LEVEL_WIDTH +: LEVEL_WIDTH] < level_q);
    end
  end

  // A request set is consumed only when neither frozen nor killed.
  assign accept = !bus.stall && !bus.flush && (|bus.reqValid);

  always_comb begin
    level_d     = bus.levelWe ? bus.levelIn : level_q;
    lfsr_d      = lfsr_q;
    dec_valid_d = dec_valid_q;
    dec_skip_d  = dec_skip_q;
    if (accept) begin
      lfsr_d = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
    end
    if (!bus.stall) begin
      if (bus.flush) begin
        dec_valid_d = '0;
        dec_skip_d  = '0;
      end else begin
        dec_valid_d = bus.reqValid;
        dec_skip_d  = skip_vec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= '0;
      lfsr_q      <= SEED_EFF;
      dec_valid_q <= '0;
      dec_skip_q  <= '0;
    end else begin
      level_q     <= level_d;
      lfsr_q      <= lfsr_d;
      dec_valid_q <= dec_valid_d;
      dec_skip_q  <= dec_skip_d;
    end
  end

  assign bus.level    = level_q;
  assign bus.decValid = dec_valid_q;
  assign bus.decSkip  = dec_skip_q;

`ifdef RSD_AX_DECISION_STATS_EN
  localparam int POP_W = $clog2(LANE_NUM + 1);

  logic [STAT_WIDTH-1:0] stat_req_q, stat_req_d;
  logic [STAT_WIDTH-1:0] stat_skip_q, stat_skip_d;
  logic [POP_W-1:0]      req_pop, skip_pop;
  logic [STAT_WIDTH:0]   req_sum, skip_sum;
  logic                  stat_update;

  assign stat_update = !bus.stall && !bus.flush;

  // The extra sum bit is the carry that pins each counter at all-ones.
  always_comb begin
    req_pop  = '0;
    skip_pop = '0;
    for (int i = 0; i < LANE_NUM; i++) begin
      req_pop  = req_pop  + POP_W'(bus.reqValid[i]);
      skip_pop = skip_pop + POP_W'(skip_vec[i]);
    end
    req_sum     = {1'b0, stat_req_q}  + (STAT_WIDTH+1)'(req_pop);
    skip_sum    = {1'b0, stat_skip_q} + (STAT_WIDTH+1)'(skip_pop);
    stat_req_d  = stat_req_q;
    stat_skip_d = stat_skip_q;
    if (bus.statClear) begin
      stat_req_d  = '0;
      stat_skip_d = '0;
    end else if (stat_update) begin
      stat_req_d  = req_sum[STAT_WIDTH]  ? '1 : req_sum[STAT_WIDTH-1:0];
      stat_skip_d = skip_sum[STAT_WIDTH] ? '1 : skip_sum[STAT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_req_q  <= '0;
      stat_skip_q <= '0;
    end else begin
      stat_req_q  <= stat_req_d;
      stat_skip_q <= stat_skip_d;
    end
  end

  assign bus.statReqCount  = stat_req_q;
  assign bus.statSkipCount = stat_skip_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear  = bus.statClear;
  assign bus.statReqCount   = '0;
  assign bus.statSkipCount  = '0;
`endif

endmodule

// File: tb/tb_ax_skip_decider.sv
// Directed bench for ax_skip_decider with hand-computed LFSR samples and decisions.
// Counter expectations follow whichever build RSD_AX_DECISION_STATS_EN selects.
module tb_ax_skip_decider;
  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;

  ax_skip_decider_if #(.LEVEL_WIDTH(5), .LANE_NUM(2), .STAT_WIDTH(32)) bus ();

  ax_skip_decider #(
    .LFSR_WIDTH(32), .LFSR_SEED(32'h1010), .LEVEL_WIDTH(5),
    .LANE_NUM(2), .STAT_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] statExp(input logic [31:0] v);
`ifdef RSD_AX_DECISION_STATS_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, and settle just after it.
  task automatic applyStimulus(input logic we, input logic [4:0] lin, input logic st,
                               input logic fl, input logic [1:0] req, input logic clr);
    bus.levelWe   = we;
    bus.levelIn   = lin;
    bus.stall     = st;
    bus.flush     = fl;
    bus.reqValid  = req;
    bus.statClear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkDecision(input string tag, input logic [1:0] v, input logic [1:0] s,
                               input logic [31:0] lfsr, input logic [31:0] rc,
                               input logic [31:0] sc);
    checkOutput({tag, ".valid"}, 64'(bus.decValid), 64'(v));
    checkOutput({tag, ".skip"},  64'(bus.decSkip),  64'(s));
    checkOutput({tag, ".lfsr"},  64'(dut.lfsr_q),   64'(lfsr));
    checkOutput({tag, ".req"},   64'(bus.statReqCount),  64'(statExp(rc)));
    checkOutput({tag, ".skc"},   64'(bus.statSkipCount), 64'(statExp(sc)));
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    checkOutput("rst.valid", 64'(bus.decValid), 64'h0);
    checkOutput("rst.skip",  64'(bus.decSkip),  64'h0);
    checkOutput("rst.level", 64'(bus.level),    64'h0);
    checkOutput("rst.lfsr",  64'(dut.lfsr_q),   64'h1010);
    checkOutput("rst.req",   64'(bus.statReqCount),  64'h0);
    checkOutput("rst.skc",   64'(bus.statSkipCount), 64'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    bus.levelWe = 1'b0; bus.levelIn = '0; bus.stall = 1'b0;
    bus.flush = 1'b0; bus.reqValid = '0; bus.statClear = 1'b0;
    rst = 1'b0;
    #3;
    doReset();

    // Level 0 never skips; seed shifts right while its LSB is 0.
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("l0c1", 2'b11, 2'b00, 32'h0808, 2, 0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("l0c2", 2'b11, 2'b00, 32'h0404, 4, 0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("l0c3", 2'b11, 2'b00, 32'h0202, 6, 0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("l0c4", 2'b11, 2'b00, 32'h0101, 8, 0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    checkDecision("idle", 2'b00, 2'b00, 32'h0101, 8, 0);

    // Level 16: s0=16,s1=0 then s0=8,s1=0.
    doReset();
    applyStimulus(1'b1, 5'd16, 1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("lvl16", 64'(bus.level), 64'd16);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("l16c1", 2'b11, 2'b10, 32'h0808, 2, 1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("l16c2", 2'b11, 2'b11, 32'h0404, 4, 3);

    // Same-cycle level write still decides against the old level.
    doReset();
    applyStimulus(1'b1, 5'd31, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("wr31c1", 2'b11, 2'b00, 32'h0808, 2, 0);
    checkOutput("lvl31", 64'(bus.level), 64'd31);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("wr31c2", 2'b11, 2'b11, 32'h0404, 4, 2);

    // Stall freezes everything; a flush inside it is ignored and forgotten.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    checkDecision("stall1", 2'b11, 2'b11, 32'h0404, 4, 2);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 2'b11, 1'b0);
    checkDecision("stall2", 2'b11, 2'b11, 32'h0404, 4, 2);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 2'b01, 1'b0);
    checkDecision("stall3", 2'b11, 2'b11, 32'h0404, 4, 2);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("resume", 2'b11, 2'b11, 32'h0202, 6, 4);

    // statClear acts even while stalled.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1);
    checkDecision("clrstl", 2'b11, 2'b11, 32'h0202, 0, 0);

    // Flush kills the in-flight set and blocks the LFSR step and counters.
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0);
    checkDecision("preflush", 2'b01, 2'b01, 32'h0101, 1, 1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0);
    checkDecision("flush", 2'b00, 2'b00, 32'h0101, 1, 1);

`ifdef RSD_AX_DECISION_STATS_EN
    force dut.stat_req_q  = 32'hFFFF_FFFE;
    force dut.stat_skip_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_req_q;
    release dut.stat_skip_q;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("sat", 2'b11, 2'b11, 32'h8020_0083, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    // LSB of 0x0101 is set, so this step applies the feedback mask.
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkDecision("mask", 2'b11, 2'b11, 32'h8020_0083, 0, 0);
`endif
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1);
    checkDecision("clear", 2'b00, 2'b00, 32'h8020_0083, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
